// File: rtl/masked_weight_count.sv
// Serial masked Hamming weight of a Boolean-masked ternary polynomial.
// The nonzero test and the carry chain go through HPC2 gadgets, so the weight is never unmasked.

module MSKand_HPC2 #(
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic [D-1:0]         ina,
  input  logic [D-1:0]         inb,
  input  logic [D*(D-1)/2-1:0] rnd,
  output logic [D-1:0]         out_c
);
  genvar gi, gj;
  generate
    for (gi = 0; gi < D; gi++) begin : g_row
      logic         b_q;
      logic         prod_q;
      logic [D-1:0] cross_row;

      always_ff @(posedge clk) begin
        b_q    <= inb[gi];
        prod_q <= ina[gi] & b_q;
      end

      for (gj = 0; gj < D; gj++) begin : g_col
        if (gj == gi) begin : g_diag
          assign cross_row[gj] = 1'b0;
        end else begin : g_pair
          localparam int LO = (gi < gj) ? gi : gj;
          localparam int HI = (gi < gj) ? gj : gi;
          localparam int RI = LO * D - LO * (LO + 1) / 2 + (HI - LO - 1);
          logic mix_q;
          logic rnd_q;
          logic cross_q;
          // Pair (i,j) and (j,i) share r_ij, so the randomness cancels in the recombined output.
          always_ff @(posedge clk) begin
            mix_q   <= inb[gj] ^ rnd[RI];
            rnd_q   <= rnd[RI];
            cross_q <= (ina[gi] & mix_q) ^ (~ina[gi] & rnd_q);
          end
          assign cross_row[gj] = cross_q;
        end
      end

      assign out_c[gi] = prod_q ^ (^cross_row);
    end
  endgenerate
endmodule

module MSKor_HPC2 #(
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic [D-1:0]         ina,
  input  logic [D-1:0]         inb,
  input  logic [D*(D-1)/2-1:0] rnd,
  output logic [D-1:0]         out_c
);
  // a | b = ~(~a & ~b); a masked NOT flips share 0 only.
  localparam logic [D-1:0] FLIP = {{(D-1){1'b0}}, 1'b1};
  logic [D-1:0] and_c;

  MSKand_HPC2 #(.D(D)) u_and (
    .clk  (clk),
    .ina  (ina ^ FLIP),
    .inb  (inb ^ FLIP),
    .rnd  (rnd),
    .out_c(and_c)
  );

  assign out_c = and_c ^ FLIP;
endmodule

module masked_weight_count #(
  parameter int D    = 2,
  parameter int P    = 761,
  parameter int WORD = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*D-1:0]        coeff_in,
  input  logic                  coeff_valid,
  output logic                  coeff_ready,
  input  logic [D*(D-1)-1:0]    rnd,
  output logic [D*WORD-1:0]     weight_out,
  output logic                  weight_valid,
  output logic                  busy
);
  localparam int NR = D * (D - 1) / 2;

  typedef enum logic [2:0] {IDLE, WAIT_COEF, NZ, INC, DONE} state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [3:0]        bit_q, bit_d;
  logic [9:0]        idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [2*D-1:0]    coef_q, coef_d;
  logic [D-1:0]      a_q, a_d;
  logic [D*WORD-1:0] cnt_q, cnt_d;

  logic [D-1:0]      nz_c;
  logic [D-1:0]      carry_c;
  logic [D-1:0]      cur_c;

  MSKor_HPC2 #(.D(D)) u_nz (
    .clk  (clk),
    .ina  (coef_q[D-1:0]),
    .inb  (coef_q[2*D-1:D]),
    .rnd  (rnd[NR-1:0]),
    .out_c(nz_c)
  );

  MSKand_HPC2 #(.D(D)) u_carry (
    .clk  (clk),
    .ina  (a_q),
    .inb  (cur_c),
    .rnd  (rnd[2*NR-1:NR]),
    .out_c(carry_c)
  );

  assign cur_c = (bit_q == 4'd0) ? nz_c : carry_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      bit_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      coef_q  <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      coef_q  <= coef_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    pend_d  = 1'b0;
    coef_d  = coef_q;
    a_d     = a_q;
    cnt_d   = cnt_q;

    // c_9 emerges one cycle after the last INC step, so the top bit is folded in here.
    if (pend_q) begin
      cnt_d[D*(WORD-1) +: D] = cnt_q[D*(WORD-1) +: D] ^ carry_c;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT_COEF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      WAIT_COEF: begin
        if (coeff_valid) begin
          coef_d  = coeff_in;
          phase_d = 1'b0;
          state_d = NZ;
        end
      end
      NZ: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = INC;
          bit_d   = '0;
        end
      end
      INC: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          for (int b = 0; b < WORD - 1; b++) begin
            if (bit_q == 4'(b)) begin
              a_d                = cnt_q[D*b +: D];
              cnt_d[D*b +: D]    = cnt_q[D*b +: D] ^ cur_c;
            end
          end
        end else begin
          phase_d = 1'b0;
          if (bit_q == 4'(WORD - 2)) begin
            idx_d   = idx_q + 10'd1;
            pend_d  = 1'b1;
            state_d = (idx_q + 10'd1 == 10'(P)) ? DONE : WAIT_COEF;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign coeff_ready  = (state_q == WAIT_COEF);
  assign busy         = (state_q == WAIT_COEF) || (state_q == NZ) || (state_q == INC);
  // Held off for the cycle in which bit 9 is still being updated.
  assign weight_valid = (state_q == DONE) && !pend_q;
  assign weight_out   = weight_valid ? cnt_q : '0;
endmodule

// File: tb/tb_masked_weight_count.sv
// Directed bench for masked_weight_count: three instances (p = 761, 1023, 37) share one driver.
// Expected weights are the hand-counted nonzeros of each directed polynomial.

module tb_masked_weight_count;
  localparam int D = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2*D-1:0]   coeff_in;
  logic             coeff_valid;
  logic [D*(D-1)-1:0] rnd_a, rnd_b, rnd_c;

  logic             ready_a, ready_b, ready_c;
  logic             wv_a, wv_b, wv_c;
  logic             busy_a, busy_b, busy_c;
  logic [D*10-1:0]  wout_a, wout_b, wout_c;

  logic             ready_m, wv_m, busy_m;
  logic [D*10-1:0]  wout_m;

  int sel = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int coef [0:1022];

  int sp_min, sp_max, early_cnt;
  bit tmo;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rnd_a = (D*(D-1))'($urandom);
    rnd_b = (D*(D-1))'($urandom);
    rnd_c = (D*(D-1))'($urandom);
  end

  masked_weight_count #(.D(D), .P(761), .WORD(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .coeff_in(coeff_in),
    .coeff_valid(coeff_valid && sel == 0), .coeff_ready(ready_a), .rnd(rnd_a),
    .weight_out(wout_a), .weight_valid(wv_a), .busy(busy_a));

  masked_weight_count #(.D(D), .P(1023), .WORD(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .coeff_in(coeff_in),
    .coeff_valid(coeff_valid && sel == 1), .coeff_ready(ready_b), .rnd(rnd_b),
    .weight_out(wout_b), .weight_valid(wv_b), .busy(busy_b));

  masked_weight_count #(.D(D), .P(37), .WORD(10)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .coeff_in(coeff_in),
    .coeff_valid(coeff_valid && sel == 2), .coeff_ready(ready_c), .rnd(rnd_c),
    .weight_out(wout_c), .weight_valid(wv_c), .busy(busy_c));

  assign ready_m = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
  assign wv_m    = (sel == 0) ? wv_a    : (sel == 1) ? wv_b    : wv_c;
  assign busy_m  = (sel == 0) ? busy_a  : (sel == 1) ? busy_b  : busy_c;
  assign wout_m  = (sel == 0) ? wout_a  : (sel == 1) ? wout_b  : wout_c;

  // Random Boolean sharing of the 2-bit ternary encoding (0=00, +1=01, -1=11).
  function automatic logic [2*D-1:0] enc(input int v);
    logic [D-1:0] s0, s1;
    logic b0, b1;
    b0 = (v != 0);
    b1 = (v < 0);
    s0 = D'($urandom);
    s1 = D'($urandom);
    s0[0] = s0[0] ^ (^s0) ^ b0;
    s1[0] = s1[0] ^ (^s1) ^ b1;
    return {s1, s0};
  endfunction

  function automatic logic [9:0] unmask(input logic [D*10-1:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = ^w[D*i +: D];
    return r;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents coef[first .. first+count-1]; gaps of 0..max_gap idle cycles between offers.
  task automatic feed(input int first, input int count, input int max_gap, input int mid_start);
    int k, gap, waited, last_acc;
    bit have_acc, pulse;
    k = first;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    waited = 0; last_acc = 0; have_acc = 0; pulse = 0;
    sp_min = 1 << 30; sp_max = 0; early_cnt = 0; tmo = 0;
    while (k < first + count && !tmo) begin
      @(negedge clk);
      start = pulse;
      pulse = 0;
      if (have_acc && ready_m && (cyc - last_acc) < 21) early_cnt++;
      if (gap > 0) begin
        coeff_valid = 1'b0;
        gap--;
      end else begin
        coeff_valid = 1'b1;
        coeff_in = enc(coef[k]);
      end
      if (coeff_valid && ready_m) begin
        if (have_acc) begin
          if (cyc - last_acc < sp_min) sp_min = cyc - last_acc;
          if (cyc - last_acc > sp_max) sp_max = cyc - last_acc;
        end
        have_acc = 1;
        last_acc = cyc;
        if (k == mid_start) pulse = 1;
        k++;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        waited = 0;
      end else begin
        waited++;
        if (waited > 200) tmo = 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    coeff_valid = 1'b0;
  endtask

  task automatic wait_wv(input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (wv_m) got = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; coeff_valid = 1'b0; coeff_in = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++; if (ready_m !== 1'b0) begin errors++; $display("FAIL reset_ready inst=%0d got=%b want=0", s, ready_m); end
      checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy inst=%0d got=%b want=0", s, busy_m); end
      checks++; if (wv_m !== 1'b0) begin errors++; $display("FAIL reset_wv inst=%0d got=%b want=0", s, wv_m); end
      checks++; if (wout_m !== '0) begin errors++; $display("FAIL reset_wout inst=%0d got=%h want=0", s, wout_m); end
    end
    sel = 0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready_m !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b want=0", ready_m); end
    $display("tb: test_reset done");
  endtask

  task automatic test_all_zero();
    bit got;
    sel = 0;
    for (int k = 0; k < 761; k++) coef[k] = 0;
    do_start();
    feed(0, 761, 0, -1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL zero_accept_timeout got=%b want=0", tmo); end
    checks++; if (sp_min != 21) begin errors++; $display("FAIL zero_spacing_min got=%0d want=21", sp_min); end
    checks++; if (sp_max != 21) begin errors++; $display("FAIL zero_spacing_max got=%0d want=21", sp_max); end
    checks++; if (early_cnt != 0) begin errors++; $display("FAIL zero_ready_early got=%0d want=0", early_cnt); end
    wait_wv(60, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL zero_wv_timeout got=%b want=1", got); end
    checks++; if (unmask(wout_m) !== 10'd0) begin errors++; $display("FAIL zero_weight got=%0d want=0", unmask(wout_m)); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL zero_done_busy got=%b want=0", busy_m); end
    $display("tb: test_all_zero weight=%0d", unmask(wout_m));
  endtask

  task automatic test_alternating();
    bit got;
    int unstable;
    logic [D*10-1:0] cap;
    sel = 0;
    for (int k = 0; k < 761; k++) coef[k] = (k < 286) ? ((k % 2 == 1) ? -1 : 1) : 0;
    do_start();
    feed(0, 761, 0, -1);
    wait_wv(60, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL alt_wv_timeout got=%b want=1", got); end
    checks++; if (unmask(wout_m) !== 10'h11E) begin errors++; $display("FAIL alt_weight got=%0d want=286", unmask(wout_m)); end
    cap = wout_m;
    unstable = 0;
    repeat (40) begin
      @(negedge clk);
      if (!(wv_m === 1'b1 && wout_m === cap)) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL alt_hold_stable got=%0d unstable cycles want=0", unstable); end
    do_start();
    checks++; if (wv_m !== 1'b0) begin errors++; $display("FAIL alt_restart_wv got=%b want=0", wv_m); end
    checks++; if (wout_m !== '0) begin errors++; $display("FAIL alt_restart_wout got=%h want=0", wout_m); end
    checks++; if (ready_m !== 1'b1) begin errors++; $display("FAIL alt_restart_ready got=%b want=1", ready_m); end
    $display("tb: test_alternating weight=%0d", unmask(cap));
  endtask

  task automatic test_full_carry();
    bit got;
    sel = 1;
    for (int k = 0; k < 1023; k++) coef[k] = -1;
    do_start();
    feed(0, 1023, 0, -1);
    wait_wv(60, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL full_wv_timeout got=%b want=1", got); end
    checks++; if (unmask(wout_m) !== 10'h3FF) begin errors++; $display("FAIL full_weight got=%0d want=1023", unmask(wout_m)); end
    $display("tb: test_full_carry weight=%0d", unmask(wout_m));
  endtask

  task automatic test_back_to_back();
    bit got1, got2;
    logic [D*10-1:0] cap1, cap2;
    sel = 2;
    // Odd indices +1 and multiples of 4 as -1 over 37 coefficients: 18 + 10 = 28 nonzeros.
    for (int k = 0; k < 37; k++) coef[k] = (k % 2 == 1) ? 1 : ((k % 4 == 0) ? -1 : 0);
    do_start();
    feed(0, 37, 0, -1);
    wait_wv(60, got1);
    cap1 = wout_m;
    do_start();
    feed(0, 37, 0, -1);
    wait_wv(60, got2);
    cap2 = wout_m;
    checks++; if (!(got1 && got2)) begin errors++; $display("FAIL b2b_wv_timeout got=%b%b want=11", got1, got2); end
    checks++; if (unmask(cap1) !== 10'd28) begin errors++; $display("FAIL b2b_weight_run1 got=%0d want=28", unmask(cap1)); end
    checks++; if (unmask(cap2) !== 10'd28) begin errors++; $display("FAIL b2b_weight_run2 got=%0d want=28", unmask(cap2)); end
    checks++; if (cap1 === cap2) begin errors++; $display("FAIL b2b_shares_differ got=%h and %h want distinct", cap1, cap2); end
    $display("tb: test_back_to_back run1=%h run2=%h", cap1, cap2);
  endtask

  task automatic test_random_gaps();
    bit got;
    sel = 2;
    // Zero at multiples of 3 (13 of them), so 24 nonzeros.
    for (int k = 0; k < 37; k++) coef[k] = (k % 3 == 0) ? 0 : ((k % 2 == 0) ? 1 : -1);
    do_start();
    feed(0, 37, 30, 10);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL gaps_accept_timeout got=%b want=0", tmo); end
    checks++; if (early_cnt != 0) begin errors++; $display("FAIL gaps_ready_early got=%0d want=0", early_cnt); end
    wait_wv(60, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL gaps_wv_timeout got=%b want=1", got); end
    checks++; if (unmask(wout_m) !== 10'd24) begin errors++; $display("FAIL gaps_weight got=%0d want=24", unmask(wout_m)); end
    $display("tb: test_random_gaps weight=%0d", unmask(wout_m));
  endtask

  task automatic test_reset_midrun();
    bit got;
    sel = 0;
    for (int k = 0; k < 761; k++) coef[k] = 1;
    do_start();
    feed(0, 100, 0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ready_m !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b want=0", ready_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy_m); end
    checks++; if (wv_m !== 1'b0) begin errors++; $display("FAIL rst_mid_wv got=%b want=0", wv_m); end
    checks++; if (wout_m !== '0) begin errors++; $display("FAIL rst_mid_wout got=%h want=0", wout_m); end
    rst_n = 1'b1;
    for (int k = 0; k < 761; k++) coef[k] = 0;
    coef[0] = 1; coef[1] = -1; coef[380] = 1; coef[759] = -1; coef[760] = 1;
    do_start();
    feed(0, 761, 0, -1);
    wait_wv(60, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rst_mid_wv_timeout got=%b want=1", got); end
    checks++; if (unmask(wout_m) !== 10'd5) begin errors++; $display("FAIL rst_mid_weight got=%0d want=5", unmask(wout_m)); end
    $display("tb: test_reset_midrun weight=%0d", unmask(wout_m));
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_alternating();
    test_full_carry();
    test_back_to_back();
    test_random_gaps();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
